cgra0_conf_loader: RTL and testbench

Configuration loader sitting directly upstream of the CGRA top: it drains a valid/ready stream of 64-bit configuration words and drives the array's `conf_bus_in`. Idle cycles carry all-zero (no-op) words. After the last word it waits out the configuration-bus pipeline before pulsing `done`, so the host can safely enable the array.

---
 rtl/cgra0_conf_loader.sv | 156 +++++++++++++++
 tb/tb_cgra0_conf_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra0_conf_loader.sv
// cgra0_conf_loader
// Drains a valid/ready stream of configuration words onto the array's
// configuration bus. It pulses done only after the bus pipeline has flushed.
// Optional feature macro: CONF_LOADER_TIMEOUT_EN. When it is defined, a stall
// timeout in LOAD sets a sticky error and abandons the load.
//
// Handshake: a word transfers in any cycle where s_valid & s_ready is high.
// s_ready is a pure function of state (high only in LOAD). The source may
// raise or drop s_valid at any time. A word that is not accepted is never
// forwarded.
module cgra0_conf_loader #(
  parameter int CONF_WIDTH   = 64,
  parameter int CNT_WIDTH    = 16,
  parameter int FLUSH_CYCLES = 6
`ifdef CONF_LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT      = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [CONF_WIDTH-1:0] s_data,
  output logic [CONF_WIDTH-1:0] conf_bus_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    word_cnt_q, word_cnt_d;
  logic [FW-1:0]           flush_cnt_q, flush_cnt_d;
  logic [CONF_WIDTH-1:0]   conf_q, conf_d;
  logic                    hs;

`ifdef CONF_LOADER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT);

  logic [SW-1:0]           stall_q, stall_d;
  logic                    error_q, error_d;
`endif

  assign hs = (state_q == S_LOAD) && s_valid;

  // Next-state, counter and bus-word computation.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    flush_cnt_d = flush_cnt_q;
    conf_d      = '0;
`ifdef CONF_LOADER_TIMEOUT_EN
    stall_d     = '0;
    error_d     = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef CONF_LOADER_TIMEOUT_EN
          error_d = 1'b0;
`endif
          if (num_words != '0) begin
            state_d    = S_LOAD;
            word_cnt_d = num_words;
          end else begin
            // An empty job still waits out the pipeline before done.
            state_d     = S_FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end
        end
      end
      S_LOAD: begin
        if (hs) begin
          conf_d     = s_data;
          word_cnt_d = word_cnt_q - 1'b1;
          if (word_cnt_q == CNT_WIDTH'(1)) begin
            state_d     = S_FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end
        end
`ifdef CONF_LOADER_TIMEOUT_EN
        else begin
          stall_d = stall_q + 1'b1;
          if (stall_d == STALL_LIMIT) begin
            // Abandon the load: no flush and no done.
            state_d = S_IDLE;
            error_d = 1'b1;
            stall_d = '0;
          end
        end
`endif
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q - 1'b1;
        if (flush_cnt_q == FW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      flush_cnt_q <= '0;
      conf_q      <= '0;
`ifdef CONF_LOADER_TIMEOUT_EN
      stall_q     <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      conf_q      <= conf_d;
`ifdef CONF_LOADER_TIMEOUT_EN
      stall_q     <= stall_d;
      error_q     <= error_d;
`endif
    end
  end

  assign s_ready      = (state_q == S_LOAD);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign conf_bus_out = conf_q;
  assign dbg_state    = state_q;
`ifdef CONF_LOADER_TIMEOUT_EN
  assign error        = error_q;
`else
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_cgra0_conf_loader.sv
// Testbench for cgra0_conf_loader.
// It uses a transaction-level model that tracks words remaining and the cycle
// in which done is due. The model is checked every cycle. Directed scenarios
// add literal checks on latency and word order.
module tb_cgra0_conf_loader;

  localparam int CW = 64;
  localparam int NW = 16;
  localparam int FC = 6;
`ifdef CONF_LOADER_TIMEOUT_EN
  localparam int TO = 8;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NW-1:0] num_words = '0;
  logic          s_valid = 1'b0;
  logic [CW-1:0] s_data = '0;
  logic          s_ready;
  logic [CW-1:0] conf_bus_out;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  cgra0_conf_loader #(
    .CONF_WIDTH(CW),
    .CNT_WIDTH(NW),
    .FLUSH_CYCLES(FC)
`ifdef CONF_LOADER_TIMEOUT_EN
    ,
    .TIMEOUT(TO)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_words(num_words),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .conf_bus_out(conf_bus_out),
    .busy(busy),
    .done(done),
    .error(error),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- model (scoreboard) ----------------
  bit            m_active = 1'b0;
  int            m_left = 0;
  int            m_done_cyc = -1;
  bit            m_prev_hs = 1'b0;
  logic [CW-1:0] m_prev_data = '0;
  bit            m_error = 1'b0;
  bit            m_hs;
  bit            m_was_active;
`ifdef CONF_LOADER_TIMEOUT_EN
  int            m_stall = 0;
`endif
  logic          e_ready, e_busy, e_done, e_err;
  logic [CW-1:0] e_conf;

  // Expected-word queue plus observation logs for the directed literal checks.
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] seen_data[$];
  int            seen_cyc[$];
  int            done_cyc[$];

  function automatic logic [CW-1:0] seen_at(input int i);
    if (i < seen_data.size()) return seen_data[i];
    return 'x;
  endfunction

  function automatic int seen_cyc_at(input int i);
    if (i < seen_cyc.size()) return seen_cyc[i];
    return -1000;
  endfunction

  function automatic int done_at(input int i);
    if (i < done_cyc.size()) return done_cyc[i];
    return -1000;
  endfunction

  // Compare process: every cycle, checked against the model at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_left = 0; m_done_cyc = -1;
      m_prev_hs = 1'b0; m_prev_data = '0; m_error = 1'b0;
`ifdef CONF_LOADER_TIMEOUT_EN
      m_stall = 0;
`endif
    end
    e_busy  = m_active;
    e_ready = m_active && (m_left > 0);
    e_done  = (cyc == m_done_cyc);
    e_conf  = m_prev_hs ? m_prev_data : '0;
    e_err   = m_error;

    check("s_ready", CW'(s_ready), CW'(e_ready));
    check("busy", CW'(busy), CW'(e_busy));
    check("done", CW'(done), CW'(e_done));
    check("error", CW'(error), CW'(e_err));
    check("conf_bus_out", conf_bus_out, e_conf);

    if (conf_bus_out !== '0) begin
      seen_data.push_back(conf_bus_out);
      seen_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);

    if (!rst) begin
      m_was_active = m_active;
      m_hs = e_ready && s_valid;
      if (m_hs) begin
        m_left--;
        if (m_left == 0) m_done_cyc = cyc + FC + 1;
`ifdef CONF_LOADER_TIMEOUT_EN
        m_stall = 0;
`endif
      end
`ifdef CONF_LOADER_TIMEOUT_EN
      if (e_ready && !m_hs) begin
        m_stall++;
        if (m_stall == TO) begin
          m_active = 1'b0; m_error = 1'b1; m_stall = 0; m_left = 0;
        end
      end
`endif
      if (m_was_active && cyc == m_done_cyc) begin
        m_active = 1'b0;
      end else if (!m_was_active && start) begin
        m_active = 1'b1;
        m_left   = int'(num_words);
        m_error  = 1'b0;
`ifdef CONF_LOADER_TIMEOUT_EN
        m_stall  = 0;
`endif
        if (num_words == '0) m_done_cyc = cyc + FC + 1;
      end
      m_prev_hs   = m_hs;
      m_prev_data = s_data;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    seen_data.delete();
    seen_cyc.delete();
    done_cyc.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy === 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    check("idle_wait", CW'(busy), '0);
  endtask

  task automatic check_words(input string name);
    check_int({name, "_count"}, seen_data.size(), exp_q.size());
    foreach (exp_q[i]) check(name, seen_at(i), exp_q[i]);
  endtask

  // ---------------- directed stimulus ----------------
  int s0;

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();

    // Basic 3-word load, back to back.
    clear_logs();
    exp_q = '{64'hA, 64'hB, 64'hC};
    s0 = cyc;
    start = 1'b1; num_words = 16'd3;
    step();
    start = 1'b0; s_valid = 1'b1; s_data = 64'hA;
    step(); s_data = 64'hB;
    step(); s_data = 64'hC;
    step(); s_valid = 1'b0; s_data = '0;
    wait_idle(30);
    check_words("t1_word");
    check_int("t1_first_latency", seen_cyc_at(0) - s0, 2);
    check_int("t1_no_bubbles", seen_cyc_at(2) - seen_cyc_at(0), 2);
    check_int("t1_done_count", done_cyc.size(), 1);
    check_int("t1_done_after_hs", done_at(0) - (seen_cyc_at(2) - 1), 7);

    // Bubbles between two words.
    clear_logs();
    exp_q = '{64'h11, 64'h22};
    start = 1'b1; num_words = 16'd2;
    step();
    start = 1'b0; s_valid = 1'b1; s_data = 64'h11;
    step(); s_valid = 1'b0; s_data = 64'hFF;
    repeat (3) step();
    s_valid = 1'b1; s_data = 64'h22;
    step(); s_valid = 1'b0; s_data = '0;
    wait_idle(30);
    check_words("t2_word");
    check_int("t2_gap", seen_cyc_at(1) - seen_cyc_at(0), 4);
    check_int("t2_done_count", done_cyc.size(), 1);
    check_int("t2_done_after_hs", done_at(0) - (seen_cyc_at(1) - 1), 7);

    // Zero-word job; data offered but never consumed.
    clear_logs();
    s0 = cyc;
    start = 1'b1; num_words = 16'd0;
    step();
    start = 1'b0; s_valid = 1'b1; s_data = 64'hDEAD;
    wait_idle(30);
    s_valid = 1'b0; s_data = '0;
    check_words("t3_word");
    check_int("t3_done_count", done_cyc.size(), 1);
    check_int("t3_done_after_start", done_at(0) - s0, 7);

    // Start while busy: a second start is ignored.
    clear_logs();
    exp_q = '{64'h21, 64'h22};
    start = 1'b1; num_words = 16'd2;
    step();
    num_words = 16'd5; s_valid = 1'b1; s_data = 64'h21;
    step(); s_data = 64'h22;
    step(); s_data = 64'h23;
    step(); start = 1'b0; s_data = 64'h24;
    step(); s_data = 64'h25;
    step(); s_valid = 1'b0; s_data = '0;
    wait_idle(30);
    check_words("t4_word");
    check_int("t4_done_count", done_cyc.size(), 1);
    check("t4_idle_state_busy", CW'(busy), '0);

    // Reset in the middle of a 4-word load.
    clear_logs();
    start = 1'b1; num_words = 16'd4;
    step();
    start = 1'b0; s_valid = 1'b1; s_data = 64'h31;
    step(); s_valid = 1'b0; s_data = '0;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", CW'(busy), '0);
    check("t5_rst_ready", CW'(s_ready), '0);
    check("t5_rst_conf", conf_bus_out, '0);
    step();
    rst = 1'b0;
    repeat (10) step();
    check_int("t5_no_done", done_cyc.size(), 0);
    clear_logs();
    exp_q = '{64'h41};
    start = 1'b1; num_words = 16'd1;
    step();
    start = 1'b0; s_valid = 1'b1; s_data = 64'h41;
    step(); s_valid = 1'b0; s_data = '0;
    wait_idle(30);
    check_words("t5_word");
    check_int("t5_done_count", done_cyc.size(), 1);

`ifdef CONF_LOADER_TIMEOUT_EN
    // Stall timeout: error, back to IDLE, no done; the next start clears it.
    clear_logs();
    start = 1'b1; num_words = 16'd2;
    step();
    start = 1'b0; s_valid = 1'b1; s_data = 64'h61;
    step(); s_valid = 1'b0; s_data = '0;
    repeat (8) step();
    check("t6_error_set", CW'(error), 64'd1);
    check("t6_idle", CW'(busy), '0);
    repeat (5) step();
    check_int("t6_no_done", done_cyc.size(), 0);
    start = 1'b1; num_words = 16'd1;
    step();
    start = 1'b0;
    check("t6_error_clear", CW'(error), '0);
    s_valid = 1'b1; s_data = 64'h62;
    step(); s_valid = 1'b0; s_data = '0;
    wait_idle(30);
    check_int("t6_done_count", done_cyc.size(), 1);
`else
    // Long stall: LOAD waits indefinitely and error stays low.
    clear_logs();
    exp_q = '{64'h51, 64'h52};
    start = 1'b1; num_words = 16'd2;
    step();
    start = 1'b0; s_valid = 1'b1; s_data = 64'h51;
    step(); s_valid = 1'b0; s_data = '0;
    repeat (20) step();
    check("t6_still_busy", CW'(busy), 64'd1);
    check("t6_no_error", CW'(error), '0);
    s_valid = 1'b1; s_data = 64'h52;
    step(); s_valid = 1'b0; s_data = '0;
    wait_idle(30);
    check_words("t6_word");
    check_int("t6_done_count", done_cyc.size(), 1);
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
